// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: pipeline request/response (master = pipeline) and data-memory bus (master = controller) bundles
interface data_mem_req_if #(parameter int N = 32);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic req_byte;
  logic req_signed;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic resp_valid;
  logic [N-1:0] resp_rdata;
  logic resp_fault;
  logic stall;
  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input req_ready, resp_valid, resp_rdata, resp_fault, stall
  );
  modport slave (
    input req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, stall
  );
endinterface

interface data_mem_bus_if #(parameter int N = 32);
  logic [N-1:0] mem_address;
  logic [N-1:0] mem_wdata;
  logic mem_read_enable;
  logic mem_write_enable;
  logic mem_isByte;
  logic [N-1:0] mem_rdata;
  modport master (
    output mem_address, mem_wdata, mem_read_enable, mem_write_enable, mem_isByte,
    input mem_rdata
  );
  modport slave (
    input mem_address, mem_wdata, mem_read_enable, mem_write_enable, mem_isByte,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage load/store sequencer; clk/rst, req (pipeline request/response/stall), mem (data_Mem strobes, address, data, isByte, read data)
module data_mem_ctrl #(
  parameter int N = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input logic clk,
  input logic rst,
  data_mem_req_if.slave req,
  data_mem_bus_if.master mem
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
  state_t state, state_nxt;
  logic write_q, signed_q, fault_q;
  logic fault, word;
  logic [DATA_WIDTH-1:0] byte_val;
  logic [N-1:0] load_val;
  always_comb begin
    word = ~req.req_byte;
    fault = (|req.req_addr[N-1:ADDR_WIDTH])
          | (word & (|req.req_addr[1:0]))
          | (word & (req.req_addr[ADDR_WIDTH-1:0] > ADDR_WIDTH'(2**ADDR_WIDTH - 4)));
    byte_val = mem.mem_rdata[DATA_WIDTH-1:0];
    load_val = mem.mem_isByte ? {{(N-DATA_WIDTH){signed_q & byte_val[DATA_WIDTH-1]}}, byte_val}
                              : mem.mem_rdata;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE   ? (req.req_valid ? (fault ? DONE : SETUP) : IDLE) :
                state == SETUP  ? STROBE :
                state == STROBE ? DONE : IDLE;
  always_comb begin
    req.req_ready = state == IDLE;
    req.stall = state != IDLE;
    req.resp_valid = state == DONE;
    req.resp_fault = (state == DONE) & fault_q;
    mem.mem_write_enable = (state == STROBE) & write_q;
    mem.mem_read_enable = (state == STROBE) & ~write_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      write_q <= 1'b0;
      signed_q <= 1'b0;
      fault_q <= 1'b0;
      mem.mem_address <= '0;
      mem.mem_wdata <= '0;
      mem.mem_isByte <= 1'b0;
      req.resp_rdata <= '0;
    end else begin
      if (state == IDLE && req.req_valid) begin
        write_q <= req.req_write;
        signed_q <= req.req_signed;
        fault_q <= fault;
        if (!fault) begin
          mem.mem_address <= req.req_addr;
          mem.mem_wdata <= req.req_wdata;
          mem.mem_isByte <= req.req_byte;
        end
      end
      if (state == STROBE && !write_q) req.resp_rdata <= load_val;
    end
endmodule
